// File: rtl/axis_pad_gearbox.sv
// Pad-ring width converter: narrow pad beats <-> wide core words on AXI-Stream.
// Latency: one cycle each way (final ingress lane -> core word; core word -> first pad beat).
// Backpressure: ingress stalls only word-completing beats; egress accepts a new word only on the final beat.
//
// Ports:
//   axi_clk, axi_reset          single clock, asynchronous active-high reset
//   pad_s_valid/data/last/ready IN_PAD_W-bit ingress beats from the pads
//   core_m_valid/data/last/ready IN_W-bit assembled words to the core
//   core_s_valid/data/last/ready OUT_W-bit result words from the core
//   pad_m_valid/data/last/ready OUT_PAD_W-bit egress beats to the pads
//   short_frame                 sticky: an ingress frame ended on a partial word
module axis_pad_gearbox #(
  parameter int IN_PAD_W  = 8,
  parameter int IN_W      = 32,
  parameter int OUT_W     = 16,
  parameter int OUT_PAD_W = 4
) (
  input  logic                 axi_clk,
  input  logic                 axi_reset,

  input  logic                 pad_s_valid,
  input  logic [IN_PAD_W-1:0]  pad_s_data,
  input  logic                 pad_s_last,
  output logic                 pad_s_ready,

  output logic                 core_m_valid,
  output logic [IN_W-1:0]      core_m_data,
  output logic                 core_m_last,
  input  logic                 core_m_ready,

  input  logic                 core_s_valid,
  input  logic [OUT_W-1:0]     core_s_data,
  input  logic                 core_s_last,
  output logic                 core_s_ready,

  output logic                 pad_m_valid,
  output logic [OUT_PAD_W-1:0] pad_m_data,
  output logic                 pad_m_last,
  input  logic                 pad_m_ready,

  output logic                 short_frame
);

  localparam int R_IN   = IN_W / IN_PAD_W;
  localparam int R_OUT  = OUT_W / OUT_PAD_W;
  localparam int CNT_W  = (R_IN  > 1) ? $clog2(R_IN)  : 1;
  localparam int BCNT_W = (R_OUT > 1) ? $clog2(R_OUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(R_IN - 1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(R_OUT - 1);

  // Reject parameter sets that cannot be split into whole lanes.
  generate
    if ((IN_W % IN_PAD_W) != 0) begin : g_bad_in_ratio
      $error("axis_pad_gearbox: IN_W must be a multiple of IN_PAD_W");
    end
    if ((OUT_W % OUT_PAD_W) != 0) begin : g_bad_out_ratio
      $error("axis_pad_gearbox: OUT_W must be a multiple of OUT_PAD_W");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Ingress deserialiser
  // ---------------------------------------------------------------------------
  logic [IN_W-1:0]  acc;
  logic [CNT_W-1:0] cnt;
  logic             lane_last;
  logic             word_completing;
  logic             in_hs;
  logic [IN_W-1:0]  lane_word;

  assign lane_last       = (cnt == CNT_LAST);
  assign word_completing = lane_last || pad_s_last;

  // Only a beat that would load the output register can be blocked; partial
  // lanes always have room in the accumulator.
  assign pad_s_ready = !(word_completing && core_m_valid && !core_m_ready);
  assign in_hs       = pad_s_valid && pad_s_ready;

  // Incoming beat placed in its little-endian lane. Lanes above cnt in acc
  // are always zero (acc clears after every word), so OR-ing yields the
  // zero-padded word on an early last as well.
  assign lane_word = IN_W'(pad_s_data) << (cnt * IN_PAD_W);

  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      acc          <= '0;
      cnt          <= '0;
      core_m_valid <= 1'b0;
      core_m_data  <= '0;
      core_m_last  <= 1'b0;
      short_frame  <= 1'b0;
    end else begin
      if (core_m_valid && core_m_ready) begin
        core_m_valid <= 1'b0;
      end
      if (in_hs) begin
        if (word_completing) begin
          // pad_s_ready guarantees the output register is free or draining.
          core_m_valid <= 1'b1;
          core_m_data  <= acc | lane_word;
          core_m_last  <= pad_s_last;
          acc          <= '0;
          cnt          <= '0;
          if (!lane_last) begin
            short_frame <= 1'b1;
          end
        end else begin
          acc <= acc | lane_word;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Egress serialiser
  // ---------------------------------------------------------------------------
  logic [OUT_W-1:0]  sh;
  logic [BCNT_W-1:0] bcnt;
  logic              saved_last;
  logic              beat_final;
  logic              core_hs;
  logic              pad_hs;

  assign beat_final   = (bcnt == BCNT_LAST);
  // A new word may enter as the last beat of the current one leaves, which
  // keeps back-to-back words free of bubbles.
  assign core_s_ready = !pad_m_valid || (pad_m_ready && beat_final);
  assign core_hs      = core_s_valid && core_s_ready;
  assign pad_hs       = pad_m_valid && pad_m_ready;
  assign pad_m_data   = sh[OUT_PAD_W-1:0];

  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      sh          <= '0;
      bcnt        <= '0;
      saved_last  <= 1'b0;
      pad_m_valid <= 1'b0;
      pad_m_last  <= 1'b0;
    end else if (core_hs) begin
      sh          <= core_s_data;
      bcnt        <= '0;
      saved_last  <= core_s_last;
      pad_m_valid <= 1'b1;
      // With a single beat per word the first beat is also the final one.
      pad_m_last  <= core_s_last && (R_OUT == 1);
    end else if (pad_hs) begin
      sh <= sh >> OUT_PAD_W;
      if (beat_final) begin
        pad_m_valid <= 1'b0;
        bcnt        <= '0;
        pad_m_last  <= 1'b0;
      end else begin
        bcnt       <= bcnt + 1'b1;
        // pad_m_last is precomputed so it leaves a flop directly.
        pad_m_last <= saved_last && ((bcnt + 1'b1) == BCNT_LAST);
      end
    end
  end

endmodule

// File: tb/tb_axis_pad_gearbox.sv
module tb_axis_pad_gearbox;

  localparam int IN_PAD_W  = 8;
  localparam int IN_W      = 32;
  localparam int OUT_W     = 16;
  localparam int OUT_PAD_W = 4;
  localparam int R_IN      = IN_W / IN_PAD_W;
  localparam int R_OUT     = OUT_W / OUT_PAD_W;

  logic                 axi_clk = 1'b0;
  logic                 axi_reset = 1'b1;
  logic                 pad_s_valid = 1'b0;
  logic [IN_PAD_W-1:0]  pad_s_data = '0;
  logic                 pad_s_last = 1'b0;
  logic                 pad_s_ready;
  logic                 core_m_valid;
  logic [IN_W-1:0]      core_m_data;
  logic                 core_m_last;
  logic                 core_m_ready = 1'b0;
  logic                 core_s_valid = 1'b0;
  logic [OUT_W-1:0]     core_s_data = '0;
  logic                 core_s_last = 1'b0;
  logic                 core_s_ready;
  logic                 pad_m_valid;
  logic [OUT_PAD_W-1:0] pad_m_data;
  logic                 pad_m_last;
  logic                 pad_m_ready = 1'b0;
  logic                 short_frame;

  axis_pad_gearbox #(
    .IN_PAD_W (IN_PAD_W),
    .IN_W     (IN_W),
    .OUT_W    (OUT_W),
    .OUT_PAD_W(OUT_PAD_W)
  ) dut (
    .axi_clk     (axi_clk),
    .axi_reset   (axi_reset),
    .pad_s_valid (pad_s_valid),
    .pad_s_data  (pad_s_data),
    .pad_s_last  (pad_s_last),
    .pad_s_ready (pad_s_ready),
    .core_m_valid(core_m_valid),
    .core_m_data (core_m_data),
    .core_m_last (core_m_last),
    .core_m_ready(core_m_ready),
    .core_s_valid(core_s_valid),
    .core_s_data (core_s_data),
    .core_s_last (core_s_last),
    .core_s_ready(core_s_ready),
    .pad_m_valid (pad_m_valid),
    .pad_m_data  (pad_m_data),
    .pad_m_last  (pad_m_last),
    .pad_m_ready (pad_m_ready),
    .short_frame (short_frame)
  );

  always #5 axi_clk = ~axi_clk;

  typedef struct packed {
    logic [IN_W-1:0] d;
    logic            l;
  } in_exp_t;

  typedef struct packed {
    logic [OUT_PAD_W-1:0] d;
    logic                 l;
  } out_exp_t;

  in_exp_t             exp_in[$];
  out_exp_t            exp_out[$];
  logic [IN_PAD_W-1:0] in_lanes[$];
  logic                sf_model = 1'b0;

  int   checks = 0;
  int   errors = 0;
  bit   rand_in = 1'b0;
  bit   rand_pad = 1'b0;
  logic in_rdy_fix = 1'b1;
  logic pad_rdy_fix = 1'b1;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Sink-side ready generators, updated shortly after each rising edge.
  always @(posedge axi_clk) begin
    #2;
    core_m_ready = rand_in  ? 1'($urandom_range(0, 1)) : in_rdy_fix;
    pad_m_ready  = rand_pad ? 1'($urandom_range(0, 1)) : pad_rdy_fix;
  end

  // Reference: collect lanes; a word closes after R_IN lanes or on last.
  function automatic void model_in(input logic [IN_PAD_W-1:0] d, input logic l);
    in_exp_t         e;
    logic [IN_W-1:0] w;
    in_lanes.push_back(d);
    if (in_lanes.size() == R_IN || l) begin
      w = '0;
      foreach (in_lanes[k]) w = w | (IN_W'(in_lanes[k]) << (k * IN_PAD_W));
      if (in_lanes.size() < R_IN) sf_model = 1'b1;
      e.d = w;
      e.l = l;
      exp_in.push_back(e);
      in_lanes.delete();
    end
  endfunction

  // Reference: a word becomes R_OUT nibbles, least significant first.
  function automatic void model_out(input logic [OUT_W-1:0] w, input logic l);
    out_exp_t e;
    for (int k = 0; k < R_OUT; k++) begin
      e.d = OUT_PAD_W'(w >> (k * OUT_PAD_W));
      e.l = l && (k == R_OUT - 1);
      exp_out.push_back(e);
    end
  endfunction

  task automatic send_in(input logic [IN_PAD_W-1:0] d, input logic l);
    int n = 0;
    pad_s_valid = 1'b1;
    pad_s_data  = d;
    pad_s_last  = l;
    @(negedge axi_clk);
    while (!pad_s_ready && n < 1000) begin
      n++;
      @(negedge axi_clk);
    end
    chk("ingress_accept_timeout", pad_s_ready, 1'b1);
    if (pad_s_ready) begin
      @(posedge axi_clk);
      model_in(d, l);
      #1;
    end
    pad_s_valid = 1'b0;
    pad_s_last  = 1'b0;
  endtask

  task automatic send_out(input logic [OUT_W-1:0] w, input logic l);
    int n = 0;
    core_s_valid = 1'b1;
    core_s_data  = w;
    core_s_last  = l;
    @(negedge axi_clk);
    while (!core_s_ready && n < 1000) begin
      n++;
      @(negedge axi_clk);
    end
    chk("egress_accept_timeout", core_s_ready, 1'b1);
    if (core_s_ready) begin
      @(posedge axi_clk);
      model_out(w, l);
      #1;
    end
    core_s_valid = 1'b0;
    core_s_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge axi_clk);
    #3;
  endtask

  task automatic check_reset();
    chk("rst_pad_s_ready",  pad_s_ready,  1'b1);
    chk("rst_core_m_valid", core_m_valid, 1'b0);
    chk("rst_core_m_data",  core_m_data,  '0);
    chk("rst_core_m_last",  core_m_last,  1'b0);
    chk("rst_core_s_ready", core_s_ready, 1'b1);
    chk("rst_pad_m_valid",  pad_m_valid,  1'b0);
    chk("rst_pad_m_data",   pad_m_data,   '0);
    chk("rst_pad_m_last",   pad_m_last,   1'b0);
    chk("rst_short_frame",  short_frame,  1'b0);
  endtask

  task automatic drain();
    rand_in     = 1'b0;
    rand_pad    = 1'b0;
    in_rdy_fix  = 1'b1;
    pad_rdy_fix = 1'b1;
    for (int i = 0; i < 500 && (exp_in.size() != 0 || exp_out.size() != 0); i++)
      @(posedge axi_clk);
    #3;
    chk("drain_ingress_pending", exp_in.size(), 0);
    chk("drain_egress_pending", exp_out.size(), 0);
  endtask

  // Monitor: compares DUT outputs against the scoreboard heads every cycle.
  always @(negedge axi_clk) begin
    if (!axi_reset) begin
      chk("core_m_valid", core_m_valid, exp_in.size() > 0);
      chk("short_frame", short_frame, sf_model);
      if (pad_s_valid)
        chk("pad_s_ready", pad_s_ready,
            !(((in_lanes.size() == R_IN - 1) || pad_s_last) &&
              exp_in.size() > 0 && !core_m_ready));
      if (core_m_valid && exp_in.size() > 0) begin
        chk("core_m_data", core_m_data, exp_in[0].d);
        chk("core_m_last", core_m_last, exp_in[0].l);
        if (core_m_ready) void'(exp_in.pop_front());
      end

      chk("pad_m_valid", pad_m_valid, exp_out.size() > 0);
      chk("core_s_ready", core_s_ready,
          (exp_out.size() == 0) || (exp_out.size() == 1 && pad_m_ready));
      if (pad_m_valid && exp_out.size() > 0) begin
        chk("pad_m_data", pad_m_data, exp_out[0].d);
        chk("pad_m_last", pad_m_last, exp_out[0].l);
        if (pad_m_ready) void'(exp_out.pop_front());
      end
    end
  end

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    #1;
    check_reset();
    idle(3);
    axi_reset = 1'b0;
    idle(1);

    // Full word at one beat per cycle.
    send_in(8'h11, 1'b0);
    send_in(8'h22, 1'b0);
    send_in(8'h33, 1'b0);
    send_in(8'h44, 1'b1);
    idle(2);

    // Short frame, then the next frame restarts at lane 0.
    send_in(8'hAA, 1'b0);
    send_in(8'hBB, 1'b1);
    send_in(8'h01, 1'b0);
    send_in(8'h02, 1'b0);
    send_in(8'h03, 1'b0);
    send_in(8'h04, 1'b1);
    idle(2);

    // Two full words against a stalled core.
    in_rdy_fix = 1'b0;
    idle(1);
    fork
      begin
        for (int i = 0; i < 8; i++) send_in(IN_PAD_W'(8'h51 + i), i == 7);
      end
      begin
        idle(14);
        in_rdy_fix = 1'b1;
      end
    join
    idle(3);

    // Egress back-to-back words.
    send_out(16'hBEEF, 1'b1);
    send_out(16'h1234, 1'b0);
    idle(6);

    // Randomised traffic on both directions with random sink readiness.
    rand_in  = 1'b1;
    rand_pad = 1'b1;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          send_in(IN_PAD_W'($urandom), $urandom_range(0, 7) == 0);
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        send_in(8'h5A, 1'b1);
      end
      begin
        for (int i = 0; i < 100; i++) begin
          send_out(OUT_W'($urandom), $urandom_range(0, 3) == 0);
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
      end
    join
    drain();

    // Reset with two ingress lanes held and one egress beat already sent.
    pad_rdy_fix = 1'b0;
    idle(1);
    send_out(16'hCAFE, 1'b0);
    send_in(8'h11, 1'b0);
    send_in(8'h22, 1'b0);
    pad_rdy_fix = 1'b1;
    @(posedge axi_clk);
    @(posedge axi_clk);
    #1;
    pad_rdy_fix = 1'b0;
    #2;
    axi_reset = 1'b1;
    #1;
    check_reset();
    exp_in.delete();
    exp_out.delete();
    in_lanes.delete();
    sf_model = 1'b0;
    pad_rdy_fix = 1'b1;
    idle(2);
    axi_reset = 1'b0;
    idle(1);

    send_in(8'h11, 1'b0);
    send_in(8'h22, 1'b0);
    send_in(8'h33, 1'b0);
    send_in(8'h44, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
